// File: rtl/tow_match_ctrl_if.sv
// Game-block side of the tug-of-war match controller: move pulses and reset out, done/winner back.
interface tow_match_ctrl_if;
  logic [1:0] game_in;
  logic       game_reset;
  logic       game_done;
  logic [1:0] game_winner;

  modport master (output game_in, output game_reset, input game_done, input game_winner);
  modport slave  (input game_in, input game_reset, output game_done, output game_winner);
endinterface

// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: key conditioning, round sequencing, scoring, match winner.
// Optional build macro TOW_TIE_ALTERNATE_EN: round-robin grant of simultaneous key pulses.
//
// state  | meaning
// NEWRND | one-cycle game reset between rounds
// PLAY   | key pulses forwarded, waiting for a scored round end
// HOLD   | finished board displayed for HOLD_CYCLES cycles
// OVER   | match won, final board held until reset
module tow_match_ctrl #(
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_CYCLES   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_l,
  input  logic              key_r,
  tow_match_ctrl_if.master  game,
  output logic [2:0]        score_l,
  output logic [2:0]        score_r,
  output logic              match_done,
  output logic [1:0]        match_winner
);

  localparam logic [1:0] ST_NEWRND = 2'd0;
  localparam logic [1:0] ST_PLAY   = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;
  localparam logic [1:0] ST_OVER   = 2'd3;

  localparam logic [2:0] WINS    = 3'(WINS_TO_MATCH);
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES);

  logic       sync_l1_q, sync_l1_d, sync_l2_q, sync_l2_d, prev_l_q, prev_l_d, edge_l_q, edge_l_d;
  logic       sync_r1_q, sync_r1_d, sync_r2_q, sync_r2_d, prev_r_q, prev_r_d, edge_r_q, edge_r_d;
  logic [1:0] state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] game_in_q, game_in_d;
  logic [2:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       match_done_q, match_done_d;
  logic [1:0] match_winner_q, match_winner_d;
`ifdef TOW_TIE_ALTERNATE_EN
  logic       tie_ptr_q, tie_ptr_d;
`endif

  // Registered edge pulse adds the third stage so a press appears three edges after sampling.
  always_comb begin
    sync_l1_d = key_l;
    sync_l2_d = sync_l1_q;
    prev_l_d  = sync_l2_q;
    edge_l_d  = sync_l2_q & ~prev_l_q;
    sync_r1_d = key_r;
    sync_r2_d = sync_r1_q;
    prev_r_d  = sync_r2_q;
    edge_r_d  = sync_r2_q & ~prev_r_q;
  end

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    score_l_d      = score_l_q;
    score_r_d      = score_r_q;
    match_done_d   = match_done_q;
    match_winner_d = match_winner_q;
    case (state_q)
      ST_NEWRND: state_d = ST_PLAY;
      ST_PLAY: begin
        if (game.game_done && game.game_winner == 2'b01) begin
          if (score_l_q < WINS) score_l_d = score_l_q + 3'd1;
          if (score_l_d == WINS) begin
            state_d        = ST_OVER;
            match_done_d   = 1'b1;
            match_winner_d = 2'b01;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LD;
          end
        end else if (game.game_done && game.game_winner == 2'b10) begin
          if (score_r_q < WINS) score_r_d = score_r_q + 3'd1;
          if (score_r_d == WINS) begin
            state_d        = ST_OVER;
            match_done_d   = 1'b1;
            match_winner_d = 2'b10;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = HOLD_LD;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q <= 8'd1) begin
          state_d    = ST_NEWRND;
          hold_cnt_d = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_NEWRND;
    endcase
  end

  // Gate on the next state so game_in is only ever non-zero while the registered state is PLAY.
  always_comb begin
    game_in_d = 2'b00;
`ifdef TOW_TIE_ALTERNATE_EN
    tie_ptr_d = tie_ptr_q;
    if (state_d == ST_PLAY) begin
      if (edge_l_q && edge_r_q) begin
        game_in_d = tie_ptr_q ? 2'b01 : 2'b10;
        tie_ptr_d = ~tie_ptr_q;
      end else begin
        game_in_d = {edge_l_q, edge_r_q};
      end
    end
`else
    if (state_d == ST_PLAY && !(edge_l_q && edge_r_q)) game_in_d = {edge_l_q, edge_r_q};
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l1_q      <= 1'b0;
      sync_l2_q      <= 1'b0;
      prev_l_q       <= 1'b0;
      edge_l_q       <= 1'b0;
      sync_r1_q      <= 1'b0;
      sync_r2_q      <= 1'b0;
      prev_r_q       <= 1'b0;
      edge_r_q       <= 1'b0;
      state_q        <= ST_NEWRND;
      hold_cnt_q     <= 8'd0;
      game_in_q      <= 2'b00;
      score_l_q      <= 3'd0;
      score_r_q      <= 3'd0;
      match_done_q   <= 1'b0;
      match_winner_q <= 2'b00;
`ifdef TOW_TIE_ALTERNATE_EN
      tie_ptr_q      <= 1'b0;
`endif
    end else begin
      sync_l1_q      <= sync_l1_d;
      sync_l2_q      <= sync_l2_d;
      prev_l_q       <= prev_l_d;
      edge_l_q       <= edge_l_d;
      sync_r1_q      <= sync_r1_d;
      sync_r2_q      <= sync_r2_d;
      prev_r_q       <= prev_r_d;
      edge_r_q       <= edge_r_d;
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      game_in_q      <= game_in_d;
      score_l_q      <= score_l_d;
      score_r_q      <= score_r_d;
      match_done_q   <= match_done_d;
      match_winner_q <= match_winner_d;
`ifdef TOW_TIE_ALTERNATE_EN
      tie_ptr_q      <= tie_ptr_d;
`endif
    end
  end

  assign game.game_in    = game_in_q;
  assign game.game_reset = reset | (state_q == ST_NEWRND);
  assign score_l         = score_l_q;
  assign score_r         = score_r_q;
  assign match_done      = match_done_q;
  assign match_winner    = match_winner_q;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Self-checking bench for tow_match_ctrl: cycle model of rounds/gaps plus literal spot checks.
module tb_tow_match_ctrl;
  localparam int W = 3;
  localparam int H = 8;

  logic       clk;
  logic       reset;
  logic       key_l;
  logic       key_r;
  logic [2:0] score_l;
  logic [2:0] score_r;
  logic       match_done;
  logic [1:0] match_winner;

  tow_match_ctrl_if gif();

  tow_match_ctrl #(.WINS_TO_MATCH(W), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset(reset), .key_l(key_l), .key_r(key_r), .game(gif),
    .score_l(score_l), .score_r(score_r), .match_done(match_done), .match_winner(match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a round gap counts remaining non-play cycles; key samples kept as a history line.
  bit   m_init = 0;
  int   m_gap;
  bit   m_over;
  int   m_sl, m_sr;
  int   m_win;
  bit   m_ptr;
  logic [1:0] m_gi;
  logic hl [0:4];
  logic hr [0:4];
  bit   rl, rr;

  always @(posedge clk) begin
    if (reset) begin
      m_gap = 1; m_over = 0; m_sl = 0; m_sr = 0; m_win = 0; m_ptr = 0; m_gi = 2'b00;
      for (int i = 0; i < 5; i++) begin hl[i] = 1'b0; hr[i] = 1'b0; end
      m_init = 1;
    end else if (m_init) begin
      for (int i = 4; i > 0; i--) begin hl[i] = hl[i-1]; hr[i] = hr[i-1]; end
      hl[0] = key_l;
      hr[0] = key_r;
      rl = hl[3] && !hl[4];
      rr = hr[3] && !hr[4];
      if (!m_over) begin
        if (m_gap > 0) m_gap--;
        else if (gif.game_done && gif.game_winner == 2'b01) begin
          m_sl++;
          if (m_sl == W) begin m_over = 1; m_win = 1; end else m_gap = H + 1;
        end else if (gif.game_done && gif.game_winner == 2'b10) begin
          m_sr++;
          if (m_sr == W) begin m_over = 1; m_win = 2; end else m_gap = H + 1;
        end
      end
      m_gi = 2'b00;
      if (!m_over && m_gap == 0) begin
        if (rl && rr) begin
`ifdef TOW_TIE_ALTERNATE_EN
          m_gi  = m_ptr ? 2'b01 : 2'b10;
          m_ptr = !m_ptr;
`endif
        end else m_gi = {rl, rr};
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int cnt_gi_l = 0, cnt_gi_r = 0, cnt_gr = 0;
  int first_l_cyc = -1;
  logic [1:0] gi_hist0 = 2'b00, gi_hist1 = 2'b00;

  always @(negedge clk) begin
    if (m_init) begin
      chk("game_in", gif.game_in, m_gi);
      chk("game_reset", gif.game_reset, reset | (!m_over && m_gap == 1));
      chk("score_l", score_l, m_sl);
      chk("score_r", score_r, m_sr);
      chk("match_done", match_done, m_over);
      chk("match_winner", match_winner, m_win);
    end
    if (gif.game_in == 2'b10) begin
      cnt_gi_l++;
      if (first_l_cyc < 0) first_l_cyc = cyc;
    end
    if (gif.game_in == 2'b01) cnt_gi_r++;
    if (gif.game_in != 2'b00) begin gi_hist1 = gi_hist0; gi_hist0 = gif.game_in; end
    if (gif.game_reset) cnt_gr++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic win(input logic [1:0] who);
    gif.game_done = 1'b1;
    gif.game_winner = who;
    step(1);
    gif.game_done = 1'b0;
    gif.game_winner = 2'b00;
  endtask

  int press_cyc, base_l, base_r, base_gr;

  initial begin
    reset = 1'b1; key_l = 1'b0; key_r = 1'b0;
    gif.game_done = 1'b0; gif.game_winner = 2'b00;
    step(3);
    chk("rst_game_reset", gif.game_reset, 1);
    chk("rst_score_l", score_l, 0);
    reset = 1'b0;
    step(2);

    // held left key: one pulse, three edges after the first sample
    key_l = 1'b1;
    press_cyc = cyc + 1;
    step(10);
    key_l = 1'b0;
    step(5);
    chk("held_key_pulses", cnt_gi_l, 1);
    chk("key_latency", first_l_cyc - press_cyc, 3);

    // winner=00 with done ignored, then left wins once
    base_gr = cnt_gr;
    gif.game_done = 1'b1; gif.game_winner = 2'b00;
    step(1);
    gif.game_winner = 2'b01;
    step(1);
    chk("score_l_once", score_l, 1);
    step(2);
    gif.game_done = 1'b0; gif.game_winner = 2'b00;
    // keys during HOLD are discarded
    base_r = cnt_gi_r;
    key_r = 1'b1;
    step(2);
    key_r = 1'b0;
    step(12);
    chk("hold_key_dropped", cnt_gi_r - base_r, 0);
    chk("round_reset_pulses", cnt_gr - base_gr, 1);
    chk("score_l_still", score_l, 1);

    // two simultaneous presses
    base_l = cnt_gi_l; base_r = cnt_gi_r;
    key_l = 1'b1; key_r = 1'b1;
    step(4);
    key_l = 1'b0; key_r = 1'b0;
    step(2);
    key_l = 1'b1; key_r = 1'b1;
    step(4);
    key_l = 1'b0; key_r = 1'b0;
    step(6);
`ifdef TOW_TIE_ALTERNATE_EN
    chk("tie_left_grants", cnt_gi_l - base_l, 1);
    chk("tie_right_grants", cnt_gi_r - base_r, 1);
    chk("tie_order_first", gi_hist1, 2'b10);
    chk("tie_order_second", gi_hist0, 2'b01);
`else
    chk("tie_left_grants", cnt_gi_l - base_l, 0);
    chk("tie_right_grants", cnt_gi_r - base_r, 0);
`endif

    // right takes the match
    for (int i = 0; i < 3; i++) begin
      win(2'b10);
      step(12);
    end
    chk("match_score_r", score_r, 3);
    chk("match_done", match_done, 1);
    chk("match_winner", match_winner, 2'b10);
    base_gr = cnt_gr;
    step(10);
    chk("over_no_reset", cnt_gr - base_gr, 0);
    reset = 1'b1;
    #1;
    chk("reset_comb", gif.game_reset, 1);
    step(1);
    reset = 1'b0;
    chk("reset_score_r", score_r, 0);
    chk("reset_match_done", match_done, 0);
    chk("reset_match_winner", match_winner, 0);
    step(2);

    // reset in the middle of HOLD with score_l=2, plus a pending key press
    win(2'b01);
    step(12);
    win(2'b01);
    chk("score_l_two", score_l, 2);
    step(2);
    key_l = 1'b1;
    step(1);
    reset = 1'b1;
    key_l = 1'b0;
    step(1);
    reset = 1'b0;
    chk("midhold_score_l", score_l, 0);
    chk("midhold_newrnd", gif.game_reset, 1);
    step(1);
    chk("midhold_play", gif.game_reset, 0);
    base_l = cnt_gi_l;
    step(6);
    chk("flushed_pulse", cnt_gi_l - base_l, 0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tow_match_ctrl.md
# tow_match_ctrl

Match controller for the tug-of-war game datapath. Conditions the two raw player keys into one-cycle, mutually exclusive move pulses, sequences rounds by resetting the game between points, keeps per-player scores and declares a match winner after a configurable number of round wins. Sits between the board keys/HEX score display and the tug-of-war position/LED block; the game block's `in`, `reset`, `done`, `winner` ports connect directly to this block.

## Interface
- `WINS_TO_MATCH`, default 3: round wins needed to take the match; legal range 1..7.
- `HOLD_CYCLES`, default 8: cycles the finished board is displayed before the next round; legal range 1..255.

- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high; restarts the whole match.
- `key_l`  in  1  raw left-player key, active-high, asynchronous to `clk`.
- `key_r`  in  1  raw right-player key, active-high, asynchronous to `clk`.
- `game_done`  in  1  from game block `done`.
- `game_winner`  in  2  from game block `winner` (01 left, 10 right, 00 none).
- `game_in`  out  2  to game block `in`; [1] left pulse, [0] right pulse; registered.
- `game_reset`  out  1  to game block `reset`.
- `score_l`  out  3  left round wins.
- `score_r`  out  3  right round wins.
- `match_done`  out  1  high once a player reaches `WINS_TO_MATCH`.
- `match_winner`  out  2  01 left, 10 right, 00 while match in progress.

## Operation
- Input conditioning per key: two-flop synchronizer, then rising-edge detect on the second flop's output (previous-value flop). A held key produces one pulse only.
- States: `NEWRND` → `PLAY` → `HOLD` → `NEWRND`…; `PLAY` → `OVER` on match win.
- `NEWRND`: `game_reset`=1 for exactly one cycle; `game_in` forced 00; go to `PLAY`.
- `PLAY`: conditioned pulses forwarded to `game_in`. Simultaneous left and right pulses in the same cycle: handled per Configuration. Round end detected when `game_done`=1 AND `game_winner`≠00 (the combinational `done` in the winning-press cycle, before `winner` is registered, is ignored). On detection: increment the matching score by 1, then go to `OVER` if the new score equals `WINS_TO_MATCH`, else to `HOLD`. Scored exactly once per round.
- `game_winner`=11 with `game_done`=1: ignored, stay in `PLAY`.
- `HOLD`: `game_in` forced 00; down-counter loaded with `HOLD_CYCLES` on entry; go to `NEWRND` when it expires. Key pulses during `HOLD` are discarded, not queued.
- `OVER`: `match_done`=1, `match_winner` = 01/10, `game_in` forced 00, game not reset (final board stays lit); left only by `reset`.
- Scores saturate at `WINS_TO_MATCH`; never wrap.
- `game_reset` = `reset` OR (state == `NEWRND`), combinational, so the game is reset in the same cycle as this block.

## Timing
- Reset values: state `NEWRND`, `game_in`=00, `score_l`=`score_r`=0, `match_done`=0, `match_winner`=00, synchronizer/edge flops 0, hold counter 0. `game_reset`=1 while `reset`=1.
- First cycle after `reset` deasserts: `NEWRND` (`game_reset`=1); `PLAY` from the next cycle.
- Key latency: raw key rising and sampled at edge N → `game_in` bit high for exactly one cycle following edge N+3.
- Round end: qualifying `game_done`/`game_winner` sampled at edge M → score updated and state `HOLD`/`OVER` after edge M; `match_done` high after edge M when match is won.
- `HOLD` lasts exactly `HOLD_CYCLES` cycles; `NEWRND` one cycle; total round gap `HOLD_CYCLES`+1 cycles of `game_in`=00.
- `reset` mid-round or mid-`HOLD`: next cycle all outputs at reset values; pending pulses in synchronizer flushed.

## Configuration
- `TOW_TIE_ALTERNATE_EN` undefined: simultaneous left+right pulses are both dropped (`game_in`=00 that cycle).
- `TOW_TIE_ALTERNATE_EN` defined: simultaneous pulses are granted round-robin; a one-bit tie pointer (reset = left) selects the winner of the tie and flips after each tie; the loser's pulse is dropped. `game_in` is never 11 in either build.

## Test plan
- Reset, `key_l` held high 10 cycles → exactly one cycle of `game_in`=10, starting 3 edges after first sample; `game_in`=00 afterwards.
- `game_done`=1, `game_winner`=00 one cycle, then `game_winner`=01 with `game_done` held → `score_l`=1 once, `HOLD` 8 cycles, `game_reset` pulse 1 cycle, then `PLAY`.
- Keys pressed during `HOLD` → `game_in` stays 00; no pulse appears after `PLAY` resumes.
- Three right-round wins (default params) → `score_r`=3, `match_done`=1, `match_winner`=10, no further `game_reset`; then `reset` → all zero, `game_reset`=1.
- Simultaneous key edges twice: undefined build → `game_in`=00 both times; `TOW_TIE_ALTERNATE_EN` build → 10 then 01.
- `reset` asserted mid-`HOLD` with `score_l`=2 → scores 0, state `NEWRND` after release.
